// File: rtl/vproc_mem_responder_if.sv
// Memory request/response bundle between a Vicuna/Ibex-style initiator and a memory target.
// master = initiator (core side), slave = memory side.
interface vproc_mem_responder_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic        mem_err;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_rvalid, mem_err, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    output mem_rvalid, mem_err, mem_rdata
  );
endinterface

// File: rtl/vproc_mem_responder.sv
// Word-addressed SRAM responder with byte-enabled writes and a fixed-latency response pipeline.
// Optional out-of-range error checking is enabled by defining MEM_RESPONDER_RANGE_CHECK_EN.
module vproc_mem_responder #(
  parameter int unsigned MEM_W       = 32,
  parameter int unsigned MEM_SZ      = 262144,
  parameter int unsigned MEM_LATENCY = 1,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] END_ADDR    = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  vproc_mem_responder_if.slave   bus,
  output logic                   prog_end_o,
  output logic [31:0]            req_cnt_o
);

  localparam int unsigned AW    = $clog2(MEM_SZ);
  localparam int unsigned WORDS = MEM_SZ / 4;

  if (MEM_W != 32) begin : g_bad_width
    $error("vproc_mem_responder: only MEM_W == 32 is supported");
  end
  if (MEM_SZ < 16 || (MEM_SZ & (MEM_SZ - 1)) != 0) begin : g_bad_size
    $error("vproc_mem_responder: MEM_SZ must be a power of two and at least 16");
  end
  if (MEM_LATENCY < 1 || MEM_LATENCY > 8) begin : g_bad_latency
    $error("vproc_mem_responder: MEM_LATENCY must be in 1..8");
  end

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  logic [31:0] ram [WORDS];
  logic [AW-3:0] idx;
  logic          oor;
  logic          wr_en;
  resp_t         stage_d;
  resp_t         pipe_q [MEM_LATENCY];
  logic          prog_end_q;
  logic [31:0]   req_cnt_q;

  logic unused_addr;
  assign unused_addr = ^{bus.mem_addr[31:AW], bus.mem_addr[1:0]};

  always_comb begin
    idx = bus.mem_addr[AW-1:2];
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    oor = |bus.mem_addr[31:AW];
`else
    oor = 1'b0;
`endif
    wr_en         = bus.mem_req & bus.mem_we & ~oor;
    // Idle and errored stages carry zero data so the outputs need no gating.
    stage_d.valid = bus.mem_req;
    stage_d.err   = bus.mem_req & oor;
    stage_d.rdata = (bus.mem_req & ~oor) ? ram[idx] : 32'h0;
  end

  // Storage is intentionally not reset; committed writes survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (bus.mem_be[i]) ram[idx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MEM_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= stage_d;
      for (int unsigned i = 1; i < MEM_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prog_end_q <= 1'b0;
      req_cnt_q  <= 32'h0;
    end else if (bus.mem_req) begin
      if (bus.mem_addr == END_ADDR) prog_end_q <= 1'b1;
      if (req_cnt_q != 32'hFFFF_FFFF) req_cnt_q <= req_cnt_q + 32'd1;
    end
  end

  assign bus.mem_rvalid = pipe_q[MEM_LATENCY-1].valid;
  assign bus.mem_err    = pipe_q[MEM_LATENCY-1].err;
  assign bus.mem_rdata  = pipe_q[MEM_LATENCY-1].rdata;
  assign prog_end_o     = prog_end_q;
  assign req_cnt_o      = req_cnt_q;

endmodule

// File: tb/tb_vproc_mem_responder.sv
// Self-checking bench: three responders (latency 1, 3, 4) driven by directed steps,
// responses checked in order and on time against a per-instance scoreboard.
module tb_vproc_mem_responder;

  localparam int unsigned LAT [3] = '{1, 3, 4};
  localparam logic [31:0] EA  [3] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct {
    int unsigned due;
    bit          chk;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic        req   [3];
  logic [31:0] addr  [3];
  logic        we    [3];
  logic [3:0]  be    [3];
  logic [31:0] wdata [3];
  logic        rv    [3];
  logic        er    [3];
  logic [31:0] rd    [3];
  logic        pe    [3];
  logic [31:0] cnt   [3];

  exp_t        sb [3][$];
  int unsigned cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vproc_mem_responder_if mif ();
    assign mif.mem_req   = req[g];
    assign mif.mem_addr  = addr[g];
    assign mif.mem_we    = we[g];
    assign mif.mem_be    = be[g];
    assign mif.mem_wdata = wdata[g];
    assign rv[g]         = mif.mem_rvalid;
    assign er[g]         = mif.mem_err;
    assign rd[g]         = mif.mem_rdata;

    vproc_mem_responder #(
      .MEM_LATENCY (LAT[g]),
      .END_ADDR    (EA[g])
    ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n[g]),
      .bus        (mif),
      .prog_end_o (pe[g]),
      .req_cnt_o  (cnt[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) req[s] = 1'b0;
    end
  endtask

  // One request on instance s; the expected response is queued for the monitor.
  task automatic issue(input int s, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input bit c, input logic x_err,
                       input logic [31:0] x_dat);
    exp_t x;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) req[k] = 1'b0;
    req[s]   = 1'b1;
    we[s]    = w;
    addr[s]  = a;
    be[s]    = b;
    wdata[s] = d;
    x.due    = cyc + LAT[s];
    x.chk    = c;
    x.err    = x_err;
    x.rdata  = x_dat;
    sb[s].push_back(x);
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (rv[s]) begin
        chk("rsp_pending", 32'(sb[s].size() > 0), 32'd1);
        if (sb[s].size() > 0) begin
          e = sb[s].pop_front();
          chk("rsp_cycle", cyc, e.due);
          if (e.chk) begin
            chk("rsp_err", 32'(er[s]), 32'(e.err));
            chk("rsp_rdata", rd[s], e.rdata);
          end
        end
      end else begin
        chk("idle_zero", {rd[s][31:1], rd[s][0] | er[s]}, 32'h0);
        if (sb[s].size() > 0) chk("rsp_late", 32'(sb[s][0].due > cyc), 32'd1);
      end
    end
  end

  initial begin
    for (int s = 0; s < 3; s++) begin
      rst_n[s] = 1'b0;
      req[s]   = 1'b0;
      addr[s]  = 32'h0;
      we[s]    = 1'b0;
      be[s]    = 4'h0;
      wdata[s] = 32'h0;
    end
    req[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", 32'(rv[0]), 32'h0);
    chk("rst_err", 32'(er[0]), 32'h0);
    chk("rst_rdata", rd[0], 32'h0);
    chk("rst_prog_end", 32'(pe[0]), 32'h0);
    chk("rst_req_cnt", cnt[0], 32'h0);
    @(negedge clk);
    for (int s = 0; s < 3; s++) rst_n[s] = 1'b1;
    req[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_empty", 32'(rv[0]), 32'h0);

    // Latency 1: write/readback, old word on write response, byte enables, range.
    issue(0, 1'b1, 32'h1000, 4'hF, 32'h0000_0000, 1'b0, 1'b0, 32'h0);
    issue(0, 1'b1, 32'h1000, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0000);
    issue(0, 1'b0, 32'h1000, 4'h0, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF);
    issue(0, 1'b1, 32'h2000, 4'hF, 32'h1122_3344, 1'b0, 1'b0, 32'h0);
    issue(0, 1'b1, 32'h2000, 4'h5, 32'hAABB_CCDD, 1'b1, 1'b0, 32'h1122_3344);
    issue(0, 1'b0, 32'h2000, 4'h0, 32'h0,         1'b1, 1'b0, 32'h11BB_33DD);
    issue(0, 1'b1, 32'h2000, 4'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h11BB_33DD);
    issue(0, 1'b0, 32'h2000, 4'h0, 32'h0,         1'b1, 1'b0, 32'h11BB_33DD);
    issue(0, 1'b1, 32'h0,    4'hF, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'h0);
    issue(0, 1'b1, 32'h0004_0000, 4'hF, 32'h1234_5678, 1'b1, RC,
          RC ? 32'h0 : 32'h5A5A_5A5A);
    issue(0, 1'b0, 32'h0004_0000, 4'h0, 32'h0, 1'b1, RC, RC ? 32'h0 : 32'h1234_5678);
    issue(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, RC ? 32'h5A5A_5A5A : 32'h1234_5678);
    idle(2);
    chk("l1_req_cnt", cnt[0], 32'd12);
    chk("l1_prog_end", 32'(pe[0]), 32'h0);

    // Latency 3: preload, reset (memory persists), then 5 back-to-back reads.
    for (int i = 0; i < 5; i++)
      issue(1, 1'b1, 32'(4 * i), 4'hF, 32'hC0DE_0000 | 32'(i), 1'b0, 1'b0, 32'h0);
    idle(5);
    @(negedge clk);
    rst_n[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    chk("l3_cnt_after_rst", cnt[1], 32'h0);
    for (int i = 0; i < 5; i++)
      issue(1, 1'b0, 32'(4 * i), 4'h0, 32'h0, 1'b1, 1'b0, 32'hC0DE_0000 | 32'(i));
    idle(1);
    chk("l3_req_cnt", cnt[1], 32'd5);
    idle(4);

    // Latency 4: sticky end flag, then reset with requests in flight.
    chk("l4_prog_end_init", 32'(pe[2]), 32'h0);
    issue(2, 1'b0, 32'h4, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    idle(1);
    chk("l4_prog_end_other", 32'(pe[2]), 32'h0);
    issue(2, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    idle(1);
    chk("l4_prog_end_set", 32'(pe[2]), 32'h1);
    idle(6);
    chk("l4_prog_end_sticky", 32'(pe[2]), 32'h1);
    for (int i = 0; i < 4; i++) issue(2, 1'b0, 32'h8, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    idle(1);
    chk("l4_rvalid_inflight", 32'(rv[2]), 32'h1);
    #2;
    rst_n[2] = 1'b0;
    sb[2].delete();
    #1;
    chk("l4_rvalid_async_rst", 32'(rv[2]), 32'h0);
    chk("l4_prog_end_rst", 32'(pe[2]), 32'h0);
    chk("l4_req_cnt_rst", cnt[2], 32'h0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    idle(8);
    chk("l4_no_rsp_after_rst", 32'(rv[2]), 32'h0);

    for (int t = 0; t < 20 && (sb[0].size() + sb[1].size() + sb[2].size()) != 0; t++) idle(1);
    chk("drain", 32'(sb[0].size() + sb[1].size() + sb[2].size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
